// File: rtl/bus_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package arb_pkg;

    typedef enum logic {IDLE, BURST} arb_state_t;

    // Width helper that never collapses to zero bits for tiny counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// One requester's attachment to the arbiter: request, burst data and grant.
interface arb_bus #(parameter int W = 8) (input logic clk);

    logic         req;
    logic         gnt;
    logic         last;
    logic [W-1:0] data;

    modport requester(output req, data, last, input gnt, clk);
    modport arbiter(input req, data, last, clk, output gnt);

endinterface

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Round-robin pick: rotate requests so ptr+1 sits at bit 0, take the lowest set
// bit, then map that position back to a requester index.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = clog2_min1(N)
)
(
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          any,
    output logic [PW-1:0] idx
);

    logic [N-1:0] w_rot;
    int           w_sel;

    always_comb begin
        w_rot = '0;
        w_sel = 0;
        any   = 1'b0;
        idx   = '0;
        for (int j = 0; j < N; j++) begin
            w_rot[j] = req[PW'((int'(ptr) + 1 + j) % N)];
        end
        // Descending scan so the lowest rotated position wins.
        for (int j = N - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                any   = 1'b1;
                w_sel = j;
            end
        end
        idx = PW'((int'(ptr) + 1 + w_sel) % N);
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready channel between N requesters; a
// grant is held for a whole burst, optionally capped at MAX_BURST beats.
module bus_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int MAX_BURST = 8
)
(
    input  logic                 clk,
    input  logic                 rst,
    arb_bus.arbiter              ports [N-1:0],
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_src,
    output logic                 busy
);

    localparam int PW = clog2_min1(N);
    localparam int CW = clog2_min1(MAX_BURST + 1);
    localparam logic [CW-1:0] CAP_LAST = CW'(MAX_BURST - 1);

    arb_state_t    r_state;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_owner;
    logic [CW-1:0] r_beatCnt;

    arb_state_t    w_stateNext;
    logic [PW-1:0] w_ptrNext;
    logic [PW-1:0] w_ownerNext;
    logic [CW-1:0] w_cntNext;

    logic [N-1:0]  w_req;
    logic [N-1:0]  w_last;
    logic [N-1:0]  w_gnt;
    logic [W-1:0]  w_data [N];
    logic          w_any;
    logic [PW-1:0] w_pick;
    logic          w_xfer;
    logic          w_capHit;

    // Interface arrays only take constant indices, so flatten them here.
    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign w_req[g]    = ports[g].req;
        assign w_last[g]   = ports[g].last;
        assign w_data[g]   = ports[g].data;
        assign ports[g].gnt = w_gnt[g];
    end

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req (w_req),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_pick)
    );

    assign w_capHit = (MAX_BURST != 0) && (r_beatCnt == CAP_LAST);

    // The reset cycle suppresses valid and grant so no beat can be handed over.
    always_comb begin
        w_stateNext = r_state;
        w_ptrNext   = r_ptr;
        w_ownerNext = r_owner;
        w_cntNext   = r_beatCnt;
        w_gnt       = '0;
        w_xfer      = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_last    = 1'b0;
        out_src     = '0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_ownerNext = w_pick;
                    w_cntNext   = '0;
                    w_stateNext = BURST;
                end
            end
            BURST: begin
                busy           = 1'b1;
                out_src        = r_owner;
                out_valid      = w_req[r_owner] && !rst;
                out_data       = w_data[r_owner];
                out_last       = w_last[r_owner] || w_capHit;
                w_gnt[r_owner] = out_ready && !rst;
                w_xfer         = out_valid && out_ready;
                if (w_xfer) begin
                    if (out_last) begin
                        w_ptrNext   = r_owner;
                        w_cntNext   = '0;
                        w_stateNext = IDLE;
                    end else if (r_beatCnt != '1) begin
                        w_cntNext = r_beatCnt + CW'(1);
                    end
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= PW'(N - 1);
            r_owner   <= '0;
            r_beatCnt <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_ptr     <= w_ptrNext;
            r_owner   <= w_ownerNext;
            r_beatCnt <= w_cntNext;
        end
    end

    always_comb begin
        if (!rst) begin
            assert ($onehot0(w_gnt));
            assert (!out_valid || busy);
            for (int i = 0; i < N; i++) begin
                assert (!w_gnt[i] || (r_state == BURST && int'(r_owner) == i));
            end
        end
    end

endmodule
